// File: rtl/bsg_idiv_pkg.sv
// Shared types and helpers for the tagged iterative divider.
// cond_negate works at a fixed maximum width; callers keep the low width_p bits (width_p < 128).
package bsg_idiv_pkg;

    localparam int bsg_idiv_max_width_lp = 128;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} bsg_idiv_state_e;

    // Two's-complement negate when neg is set; the low N bits of the result are the N-bit negation.
    function automatic logic [bsg_idiv_max_width_lp-1:0] cond_negate(
        input logic [bsg_idiv_max_width_lp-1:0] val,
        input logic                             neg
    );
        return neg ? (~val + 1'b1) : val;
    endfunction

endpackage

// File: rtl/bsg_idiv_step.sv
// One restoring radix-2 division step: shift {rem,quo} left, trial-subtract the divisor.
module bsg_idiv_step
#(
    parameter int width_p = 64
)
(
    input  logic [width_p-1:0] rem_i,
    input  logic [width_p-1:0] quo_i,
    input  logic [width_p-1:0] divisor_i,
    output logic [width_p-1:0] rem_o,
    output logic [width_p-1:0] quo_o
);

    logic [width_p:0] rem_sh;
    logic [width_p:0] diff;

    // rem < divisor on entry, so the difference always fits width_p+1 signed bits.
    always_comb begin
        rem_sh = {rem_i, quo_i[width_p-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (!diff[width_p]) begin
            rem_o = diff[width_p-1:0];
            quo_o = {quo_i[width_p-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[width_p-1:0];
            quo_o = {quo_i[width_p-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/bsg_idiv_iterative_tagged.sv
// Tagged iterative restoring divider with RISC-V divide-by-zero and signed-overflow results.
// Optional macro BSG_IDIV_FAST_DBZ_EN: divide-by-zero skips CALC/FIX and completes one cycle after accept.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one restoring step per cycle, width_p cycles
// FIX   | apply signs and special cases
// DONE  | result valid, held until yumi_i
module bsg_idiv_iterative_tagged
    import bsg_idiv_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int tag_width_p = 4
)
(
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic [width_p-1:0]     dividend_i,
    input  logic [width_p-1:0]     divisor_i,
    input  logic                   signed_div_i,
    input  logic [tag_width_p-1:0] tag_i,
    output logic                   v_o,
    output logic [width_p-1:0]     quotient_o,
    output logic [width_p-1:0]     remainder_o,
    output logic [tag_width_p-1:0] tag_o,
    output logic                   dbz_o,
    input  logic                   yumi_i
);

    localparam int cnt_w_lp = $clog2(width_p);
    localparam int pad_w_lp = bsg_idiv_max_width_lp - width_p;

    bsg_idiv_state_e state_q, state_d;

    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [width_p-1:0]     rem_q, rem_d, quo_q, quo_d;
    logic [width_p-1:0]     dvsr_q, dvsr_d, dvnd_q, dvnd_d;
    logic [tag_width_p-1:0] tag_q, tag_d;
    logic                   neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic                   signed_q, signed_d, dbz_q, dbz_d;

    logic [width_p-1:0] step_rem, step_quo;
    logic [width_p-1:0] abs_dvnd, abs_dvsr, fix_quo, fix_rem;
    logic [pad_w_lp-1:0] pad0_unused, pad1_unused, pad2_unused, pad3_unused;
    logic               fast_dbz, ovf;

`ifdef BSG_IDIV_FAST_DBZ_EN
    assign fast_dbz = (divisor_i == '0);
`else
    assign fast_dbz = 1'b0;
`endif

    assign {pad0_unused, abs_dvnd} = cond_negate(bsg_idiv_max_width_lp'(dividend_i),
                                                 signed_div_i & dividend_i[width_p-1]);
    assign {pad1_unused, abs_dvsr} = cond_negate(bsg_idiv_max_width_lp'(divisor_i),
                                                 signed_div_i & divisor_i[width_p-1]);
    assign {pad2_unused, fix_quo}  = cond_negate(bsg_idiv_max_width_lp'(quo_q), neg_quo_q);
    assign {pad3_unused, fix_rem}  = cond_negate(bsg_idiv_max_width_lp'(rem_q), neg_rem_q);

    // Most-negative / -1: |divisor| is 1 and the signs agree, so the quotient is not negated.
    assign ovf = signed_q && !neg_quo_q && (dvsr_q == width_p'(1))
              && (dvnd_q == {1'b1, {(width_p-1){1'b0}}});

    bsg_idiv_step #(.width_p(width_p)) step_u (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvsr_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            dvnd_q    <= '0;
            tag_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            signed_q  <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            dvnd_q    <= dvnd_d;
            tag_q     <= tag_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            signed_q  <= signed_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (v_i) state_d = fast_dbz ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (yumi_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_and_o = (state_q == IDLE);
        v_o         = (state_q == DONE);
        quotient_o  = quo_q;
        remainder_o = rem_q;
        tag_o       = tag_q;
        dbz_o       = dbz_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        dvnd_d    = dvnd_q;
        tag_d     = tag_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        signed_d  = signed_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: if (v_i) begin
                tag_d     = tag_i;
                signed_d  = signed_div_i;
                rem_d     = '0;
                quo_d     = abs_dvnd;
                dvsr_d    = abs_dvsr;
                dvnd_d    = dividend_i;
                neg_quo_d = signed_div_i & (dividend_i[width_p-1] ^ divisor_i[width_p-1]);
                neg_rem_d = signed_div_i & dividend_i[width_p-1];
                cnt_d     = cnt_w_lp'(width_p - 1);
                dbz_d     = 1'b0;
                if (fast_dbz) begin
                    quo_d = '1;
                    rem_d = dividend_i;
                    dbz_d = 1'b1;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                if (dvsr_q == '0) begin
                    quo_d = '1;
                    rem_d = dvnd_q;
                    dbz_d = 1'b1;
                end else if (ovf) begin
                    quo_d = dvnd_q;
                    rem_d = '0;
                end else begin
                    quo_d = fix_quo;
                    rem_d = fix_rem;
                end
            end
            default: ;
        endcase
    end

    // The consumer may only take a result that is actually being offered.
    assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_idiv_iterative_tagged.sv
// Directed self-checking bench for the tagged iterative divider at width_p=8.
module tb_bsg_idiv_iterative_tagged;

    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          v_i = 1'b0;
    logic          signed_div_i = 1'b0;
    logic          yumi_i = 1'b0;
    logic [W-1:0]  dividend_i = '0;
    logic [W-1:0]  divisor_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          ready_and_o, v_o, dbz_o;
    logic [W-1:0]  quotient_o, remainder_o;
    logic [TW-1:0] tag_o;

    int total = 0;
    int bad   = 0;

`ifdef BSG_IDIV_FAST_DBZ_EN
    localparam int DBZ_LAT = 1;
`else
    localparam int DBZ_LAT = 10;
`endif

    always #5 clk_i = ~clk_i;

    bsg_idiv_iterative_tagged #(.width_p(W), .tag_width_p(TW)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .signed_div_i(signed_div_i),
        .tag_i       (tag_i),
        .v_o         (v_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .tag_o       (tag_o),
        .dbz_o       (dbz_o),
        .yumi_i      (yumi_i)
    );

    // Issue one request from a negedge with the block idle; latency counts the accept edge as 1.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [TW-1:0] t, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic [TW-1:0] tg, output logic dz, output int lat);
        dividend_i = a; divisor_i = b; signed_div_i = s; tag_i = t; v_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 40) begin
            @(posedge clk_i); @(negedge clk_i);
            lat++;
        end
        q = quotient_o; r = remainder_o; tg = tag_o; dz = dbz_o;
        if (v_o) begin
            yumi_i = 1'b1;
            @(posedge clk_i); @(negedge clk_i);
            yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if ({ready_and_o, v_o} !== 2'b10) begin bad++; $display("FAIL reset_hs got=%b want=10", {ready_and_o, v_o}); end
        total++; if ({quotient_o, remainder_o, tag_o, dbz_o} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {quotient_o, remainder_o, tag_o, dbz_o}); end
        @(negedge clk_i); reset_n_i = 1'b1;
        @(negedge clk_i);
        total++; if (ready_and_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_and_o); end
    endtask

    task automatic test_unsigned;
        logic [W-1:0] q, r; logic [TW-1:0] tg; logic dz; int lat;
        do_op(8'd200, 8'd7, 1'b0, 4'd3, q, r, tg, dz, lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL u_lat got=%0d want=10", lat); end
        total++; if (q !== 8'd28) begin bad++; $display("FAIL u_quo got=%0d want=28", q); end
        total++; if (r !== 8'd4) begin bad++; $display("FAIL u_rem got=%0d want=4", r); end
        total++; if ({tg, dz} !== {4'd3, 1'b0}) begin bad++; $display("FAIL u_tag_dbz got=%h want=%h", {tg, dz}, {4'd3, 1'b0}); end
        total++; if ({ready_and_o, v_o} !== 2'b10) begin bad++; $display("FAIL u_after_yumi got=%b want=10", {ready_and_o, v_o}); end
        do_op(8'd255, 8'd255, 1'b0, 4'd9, q, r, tg, dz, lat);
        total++; if ({q, r, tg} !== {8'd1, 8'd0, 4'd9}) begin bad++; $display("FAIL u_max got=%h want=%h", {q, r, tg}, {8'd1, 8'd0, 4'd9}); end
        do_op(8'd3, 8'd10, 1'b0, 4'd1, q, r, tg, dz, lat);
        total++; if ({q, r} !== {8'd0, 8'd3}) begin bad++; $display("FAIL u_small got=%h want=%h", {q, r}, {8'd0, 8'd3}); end
    endtask

    task automatic test_signed;
        logic [W-1:0] q, r; logic [TW-1:0] tg; logic dz; int lat;
        do_op(8'hF9, 8'h02, 1'b1, 4'd5, q, r, tg, dz, lat);
        total++; if ({q, r, tg, dz} !== {8'hFD, 8'hFF, 4'd5, 1'b0}) begin bad++; $display("FAIL s_neg_dvnd got=%h want=%h", {q, r, tg, dz}, {8'hFD, 8'hFF, 4'd5, 1'b0}); end
        do_op(8'h07, 8'hFE, 1'b1, 4'd6, q, r, tg, dz, lat);
        total++; if ({q, r, tg} !== {8'hFD, 8'h01, 4'd6}) begin bad++; $display("FAIL s_neg_dvsr got=%h want=%h", {q, r, tg}, {8'hFD, 8'h01, 4'd6}); end
        do_op(8'hF9, 8'hFE, 1'b1, 4'd7, q, r, tg, dz, lat);
        total++; if ({q, r} !== {8'h03, 8'hFF}) begin bad++; $display("FAIL s_both_neg got=%h want=%h", {q, r}, {8'h03, 8'hFF}); end
    endtask

    task automatic test_overflow;
        logic [W-1:0] q, r; logic [TW-1:0] tg; logic dz; int lat;
        do_op(8'h80, 8'hFF, 1'b1, 4'd2, q, r, tg, dz, lat);
        total++; if ({q, r, dz} !== {8'h80, 8'h00, 1'b0}) begin bad++; $display("FAIL ovf_signed got=%h want=%h", {q, r, dz}, {8'h80, 8'h00, 1'b0}); end
        do_op(8'h80, 8'hFF, 1'b0, 4'd2, q, r, tg, dz, lat);
        total++; if ({q, r, dz} !== {8'h00, 8'h80, 1'b0}) begin bad++; $display("FAIL ovf_unsigned got=%h want=%h", {q, r, dz}, {8'h00, 8'h80, 1'b0}); end
        do_op(8'h80, 8'h01, 1'b1, 4'd2, q, r, tg, dz, lat);
        total++; if ({q, r} !== {8'h80, 8'h00}) begin bad++; $display("FAIL minneg_by_one got=%h want=%h", {q, r}, {8'h80, 8'h00}); end
    endtask

    task automatic test_dbz;
        logic [W-1:0] q, r; logic [TW-1:0] tg; logic dz; int lat;
        do_op(8'd37, 8'd0, 1'b1, 4'd4, q, r, tg, dz, lat);
        total++; if ({q, r, tg, dz} !== {8'hFF, 8'd37, 4'd4, 1'b1}) begin bad++; $display("FAIL dbz_signed got=%h want=%h", {q, r, tg, dz}, {8'hFF, 8'd37, 4'd4, 1'b1}); end
        total++; if (lat !== DBZ_LAT) begin bad++; $display("FAIL dbz_lat got=%0d want=%0d", lat, DBZ_LAT); end
        do_op(8'd37, 8'd0, 1'b0, 4'd8, q, r, tg, dz, lat);
        total++; if ({q, r, tg, dz} !== {8'hFF, 8'd37, 4'd8, 1'b1}) begin bad++; $display("FAIL dbz_unsigned got=%h want=%h", {q, r, tg, dz}, {8'hFF, 8'd37, 4'd8, 1'b1}); end
        do_op(8'hFB, 8'd0, 1'b1, 4'd1, q, r, tg, dz, lat);
        total++; if ({q, r, dz} !== {8'hFF, 8'hFB, 1'b1}) begin bad++; $display("FAIL dbz_neg got=%h want=%h", {q, r, dz}, {8'hFF, 8'hFB, 1'b1}); end
        do_op(8'd9, 8'd3, 1'b0, 4'd1, q, r, tg, dz, lat);
        total++; if ({q, r, dz} !== {8'd3, 8'd0, 1'b0}) begin bad++; $display("FAIL dbz_cleared got=%h want=%h", {q, r, dz}, {8'd3, 8'd0, 1'b0}); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a_tab [3] = '{8'd50, 8'd100, 8'd255};
        logic [W-1:0] b_tab [3] = '{8'd5, 8'd7, 8'd16};
        logic [W-1:0] q_tab [3] = '{8'd10, 8'd14, 8'd15};
        logic [W-1:0] r_tab [3] = '{8'd0, 8'd2, 8'd15};
        int acc_cyc [3] = '{0, 0, 0};
        int acc = 0, got = 0, hold = 0, cyc = 0;
        logic pend, took;
        logic [2*W+TW-1:0] snap;
        took = 1'b0;
        dividend_i = a_tab[0]; divisor_i = b_tab[0]; signed_div_i = 1'b0; tag_i = '0; v_i = 1'b1;
        while (got < 3 && cyc < 200) begin
            pend = ready_and_o && v_i;
            @(posedge clk_i); @(negedge clk_i);
            cyc++;
            if (took) begin
                total++; if (ready_and_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_yumi got=%b want=1", ready_and_o); end
            end
            took = 1'b0;
            if (pend) begin
                if (acc < 3) acc_cyc[acc] = cyc;
                acc++;
                if (acc < 3) begin
                    dividend_i = a_tab[acc]; divisor_i = b_tab[acc]; tag_i = TW'(acc);
                end else begin
                    v_i = 1'b0;
                end
            end
            yumi_i = 1'b0;
            if (v_o) begin
                total++; if (ready_and_o !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_done got=%b want=0", ready_and_o); end
                if (got == 2 && hold < 5) begin
                    if (hold == 0) snap = {quotient_o, remainder_o, tag_o};
                    else begin
                        total++; if ({quotient_o, remainder_o, tag_o} !== snap) begin bad++; $display("FAIL b2b_stable got=%h want=%h", {quotient_o, remainder_o, tag_o}, snap); end
                    end
                    hold++;
                end else begin
                    total++; if ({quotient_o, remainder_o, tag_o} !== {q_tab[got], r_tab[got], TW'(got)}) begin bad++; $display("FAIL b2b_result%0d got=%h want=%h", got, {quotient_o, remainder_o, tag_o}, {q_tab[got], r_tab[got], TW'(got)}); end
                    yumi_i = 1'b1;
                    took = 1'b1;
                    got++;
                end
            end
        end
        total++; if (got !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got); end
        total++; if (acc_cyc[1] - acc_cyc[0] !== 11) begin bad++; $display("FAIL b2b_period got=%0d want=11", acc_cyc[1] - acc_cyc[0]); end
        total++; if (hold !== 5) begin bad++; $display("FAIL b2b_hold got=%0d want=5", hold); end
        @(posedge clk_i); @(negedge clk_i);
        yumi_i = 1'b0; v_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] q, r; logic [TW-1:0] tg; logic dz; int lat; int seen;
        dividend_i = 8'd200; divisor_i = 8'd7; signed_div_i = 1'b0; tag_i = 4'd12; v_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        v_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        total++; if ({ready_and_o, v_o} !== 2'b10) begin bad++; $display("FAIL mid_reset_hs got=%b want=10", {ready_and_o, v_o}); end
        @(negedge clk_i); reset_n_i = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk_i); @(negedge clk_i);
            if (v_o) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_ghost got=%0d want=0", seen); end
        do_op(8'd100, 8'd10, 1'b0, 4'd13, q, r, tg, dz, lat);
        total++; if ({q, r, tg} !== {8'd10, 8'd0, 4'd13}) begin bad++; $display("FAIL mid_reset_next got=%h want=%h", {q, r, tg}, {8'd10, 8'd0, 4'd13}); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_dbz();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
